// File: rtl/srl_fifo_pkg.sv
// Shared constants and helpers for the SRL FIFO.
// clog2, address-width and almost-full defaults, err_flags bit indices.
package srl_fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int af_default(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Write/read handshake bundle of the SRL FIFO.
// master: producer/consumer side; slave: the FIFO itself.
interface srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);

  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic                  if_almost_full;

  modport master (
    output if_write_ce, if_write, if_din,
    output if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n,
    input  if_num_data_valid, if_almost_full
  );

  modport slave (
    input  if_write_ce, if_write, if_din,
    input  if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n,
    output if_num_data_valid, if_almost_full
  );

endinterface

// File: rtl/srl_fifo_shiftreg.sv
// SRL storage chain: shift in at slot 0 on we, read at addr.
// Ports: clk, we, addr, din, dout. No reset on storage.
module srl_fifo_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// SRL FIFO: occupancy count, registered flags, FWFT read.
// Ports: clk, reset, bus (slave); err_flags with SRL_FIFO_ERR_CHECK_EN.
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = addr_w(DEPTH),
  parameter int AF_THRESH  = af_default(DEPTH)
) (
  input  logic clk,
  input  logic reset,
`ifdef SRL_FIFO_ERR_CHECK_EN
  output logic [1:0] err_flags,
`endif
  srl_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF = (ADDR_WIDTH+1)'(AF_THRESH);

  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  push;
  logic                  pop;
  logic                  full_n;
  logic                  empty_n;
  logic                  almost_full;

  assign push = bus.if_write & bus.if_write_ce & full_n;
  assign pop  = bus.if_read & bus.if_read_ce & empty_n;

  // count-1 always fits in ADDR_WIDTH bits, so the low bits suffice
  assign rd_addr = (count == '0) ? '0
                 : count[ADDR_WIDTH-1:0] - A_ONE;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push & ~pop: count_nxt = count + CNT_ONE;
      pop & ~push: count_nxt = count - CNT_ONE;
      default:     count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      empty_n     <= 1'b0;
      full_n      <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      empty_n     <= (count_nxt != '0);
      full_n      <= (count_nxt != CNT_MAX);
      almost_full <= (count_nxt >= CNT_AF);
    end
  end

`ifdef SRL_FIFO_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flags <= '0;
    end else begin
      if (bus.if_write & bus.if_write_ce & ~full_n)
        err_flags[ERR_OVF] <= 1'b1;
      if (bus.if_read & bus.if_read_ce & ~empty_n)
        err_flags[ERR_UDF] <= 1'b1;
    end
  end
`endif

  srl_fifo_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sr (
    .clk (clk),
    .we  (push),
    .addr(rd_addr),
    .din (bus.if_din),
    .dout(bus.if_dout)
  );

  assign bus.if_full_n         = full_n;
  assign bus.if_empty_n        = empty_n;
  assign bus.if_almost_full    = almost_full;
  assign bus.if_num_data_valid = count;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl: DEPTH=4/AF=3 and DEPTH=5.
// Optional err_flags checks follow SRL_FIFO_ERR_CHECK_EN.
module tb_srl_fifo_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) b4 ();
  srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) b5 ();

`ifdef SRL_FIFO_ERR_CHECK_EN
  logic [1:0] err4;
  logic [1:0] err5;
`endif

  srl_fifo_ctrl #(
    .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .AF_THRESH(3)
  ) u4 (
    .clk(clk),
    .reset(reset),
`ifdef SRL_FIFO_ERR_CHECK_EN
    .err_flags(err4),
`endif
    .bus(b4)
  );

  srl_fifo_ctrl #(
    .DATA_WIDTH(8), .DEPTH(5), .ADDR_WIDTH(3), .AF_THRESH(4)
  ) u5 (
    .clk(clk),
    .reset(reset),
`ifdef SRL_FIFO_ERR_CHECK_EN
    .err_flags(err5),
`endif
    .bus(b5)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic w, input logic [7:0] d,
                       input logic r);
    b4.if_write = w;
    b4.if_din   = d;
    b4.if_read  = r;
    tick();
    b4.if_write = 1'b0;
    b4.if_read  = 1'b0;
  endtask

  task automatic step5(input logic w, input logic [7:0] d,
                       input logic r);
    b5.if_write = w;
    b5.if_din   = d;
    b5.if_read  = r;
    tick();
    b5.if_write = 1'b0;
    b5.if_read  = 1'b0;
  endtask

  task automatic st4(input string tag, input int n,
                     input logic e, input logic f,
                     input logic af);
    check({tag, "_cnt"}, 32'(b4.if_num_data_valid), 32'(n));
    check({tag, "_empty_n"}, 32'(b4.if_empty_n), 32'(e));
    check({tag, "_full_n"}, 32'(b4.if_full_n), 32'(f));
    check({tag, "_af"}, 32'(b4.if_almost_full), 32'(af));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v5 [5];
    v5[0] = 8'h51; v5[1] = 8'h52; v5[2] = 8'h53;
    v5[3] = 8'h54; v5[4] = 8'h55;

    reset = 1'b1;
    b4.if_write_ce = 1'b1; b4.if_write = 1'b0; b4.if_din = '0;
    b4.if_read_ce  = 1'b1; b4.if_read  = 1'b0;
    b5.if_write_ce = 1'b1; b5.if_write = 1'b0; b5.if_din = '0;
    b5.if_read_ce  = 1'b1; b5.if_read  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    st4("rst", 0, 1'b0, 1'b1, 1'b0);
    check("rst5_cnt", 32'(b5.if_num_data_valid), 0);

    step4(1'b0, 8'h00, 1'b1);
    st4("udf", 0, 1'b0, 1'b1, 1'b0);
`ifdef SRL_FIFO_ERR_CHECK_EN
    check("udf_err", 32'(err4), 32'h2);
`endif
    do_reset();
`ifdef SRL_FIFO_ERR_CHECK_EN
    check("rst_err", 32'(err4), 32'h0);
`endif

    b4.if_write_ce = 1'b0;
    for (int i = 0; i < 3; i++) step4(1'b1, 8'h77, 1'b0);
    b4.if_write_ce = 1'b1;
    st4("wce", 0, 1'b0, 1'b1, 1'b0);

    step4(1'b1, 8'h11, 1'b0);
    st4("f1", 1, 1'b1, 1'b1, 1'b0);
    check("f1_dout", 32'(b4.if_dout), 32'h11);
    step4(1'b1, 8'h22, 1'b0);
    st4("f2", 2, 1'b1, 1'b1, 1'b0);
    step4(1'b1, 8'h33, 1'b0);
    st4("f3", 3, 1'b1, 1'b1, 1'b1);
    step4(1'b1, 8'h44, 1'b0);
    st4("f4", 4, 1'b1, 1'b0, 1'b1);
    check("f4_dout", 32'(b4.if_dout), 32'h11);

    step4(1'b1, 8'h55, 1'b0);
    st4("ovf", 4, 1'b1, 1'b0, 1'b1);
    check("ovf_dout", 32'(b4.if_dout), 32'h11);
`ifdef SRL_FIFO_ERR_CHECK_EN
    check("ovf_err", 32'(err4), 32'h1);
`endif

    b4.if_read_ce = 1'b0;
    for (int i = 0; i < 3; i++) step4(1'b0, 8'h00, 1'b1);
    b4.if_read_ce = 1'b1;
    st4("rce", 4, 1'b1, 1'b0, 1'b1);

    step4(1'b0, 8'h00, 1'b1);
    st4("d1", 3, 1'b1, 1'b1, 1'b1);
    check("d1_dout", 32'(b4.if_dout), 32'h22);
    step4(1'b0, 8'h00, 1'b1);
    st4("d2", 2, 1'b1, 1'b1, 1'b0);
    check("d2_dout", 32'(b4.if_dout), 32'h33);
    step4(1'b0, 8'h00, 1'b1);
    st4("d3", 1, 1'b1, 1'b1, 1'b0);
    check("d3_dout", 32'(b4.if_dout), 32'h44);
    step4(1'b0, 8'h00, 1'b1);
    st4("d4", 0, 1'b0, 1'b1, 1'b0);

    step4(1'b1, 8'hA1, 1'b0);
    step4(1'b1, 8'hA2, 1'b0);
    check("s0_dout", 32'(b4.if_dout), 32'hA1);
    step4(1'b1, 8'hA3, 1'b1);
    st4("s1", 2, 1'b1, 1'b1, 1'b0);
    check("s1_dout", 32'(b4.if_dout), 32'hA2);
    step4(1'b0, 8'h00, 1'b1);
    check("s2_dout", 32'(b4.if_dout), 32'hA3);
    step4(1'b0, 8'h00, 1'b1);
    st4("s3", 0, 1'b0, 1'b1, 1'b0);

    step4(1'b1, 8'hB1, 1'b0);
    step4(1'b1, 8'hB2, 1'b0);
    step4(1'b1, 8'hB3, 1'b0);
    step4(1'b1, 8'hB4, 1'b0);
    step4(1'b1, 8'hC5, 1'b1);
    st4("pf", 3, 1'b1, 1'b1, 1'b1);
    check("pf_dout", 32'(b4.if_dout), 32'hB2);
    step4(1'b0, 8'h00, 1'b1);
    check("pf1_dout", 32'(b4.if_dout), 32'hB3);
    step4(1'b0, 8'h00, 1'b1);
    check("pf2_dout", 32'(b4.if_dout), 32'hB4);
    step4(1'b0, 8'h00, 1'b1);
    st4("pf3", 0, 1'b0, 1'b1, 1'b0);

    step4(1'b1, 8'hD1, 1'b1);
    st4("pe", 1, 1'b1, 1'b1, 1'b0);
    check("pe_dout", 32'(b4.if_dout), 32'hD1);
    step4(1'b0, 8'h00, 1'b1);
    st4("pe1", 0, 1'b0, 1'b1, 1'b0);

    step4(1'b1, 8'hE1, 1'b0);
    step4(1'b1, 8'hE2, 1'b0);
    step4(1'b1, 8'hE3, 1'b0);
    st4("m3", 3, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step4(1'b1, 8'hE4, 1'b0);
    reset = 1'b0;
    st4("mrst", 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step5(1'b1, v5[i], 1'b0);
      check("p5_cnt", 32'(b5.if_num_data_valid), 32'(i + 1));
    end
    check("p5_full_n", 32'(b5.if_full_n), 0);
    check("p5_af", 32'(b5.if_almost_full), 1);
    for (int i = 0; i < 5; i++) begin
      check("p5_dout", 32'(b5.if_dout), 32'(v5[i]));
      step5(1'b0, 8'h00, 1'b1);
    end
    check("p5_empty_n", 32'(b5.if_empty_n), 0);
    check("p5_full_n2", 32'(b5.if_full_n), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Parametrised shift-register (SRL) FIFO: storage shift chain plus occupancy and flag control.
- Used for start/done token channels and narrow data streams between dataflow processes in generated kernels.
- Generalises the fixed 1-bit, depth-2 start shift register to any width and depth.
- Adds full/empty handshake, an occupancy count and a programmable almost-full flag.

Parameters:
- DATA_WIDTH, 1, bits per entry (>=1).
- DEPTH, 2, number of entries (>=2, need not be a power of two).
- ADDR_WIDTH, 1, address width into the shift chain; must equal max(1, clog2(DEPTH)).
- AF_THRESH, DEPTH-1, occupancy at or above which if_almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  head-of-queue data, first-word fall-through.
- if_empty_n  out  1  high = data available.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_almost_full  out  1  high when occupancy >= AF_THRESH.

Behaviour:
- Push = if_write & if_write_ce & if_full_n.
- Pop = if_read & if_read_ce & if_empty_n.
- Requests while full or empty are ignored: no state change.
- On push, the shift chain shifts by one and if_din enters slot 0. Storage is not reset.
- Read address rd_addr = count-1, saturated at 0. if_dout = slot[rd_addr], combinational from registered state.
- Push only: count+1. Pop only: count-1. Push and pop together: count unchanged, chain shifts, if_dout presents the next-oldest entry in the same cycle as the pop edge.
- Push and pop together when count==DEPTH: push is blocked (full_n=0), so only the pop occurs.
- Push and pop together when count==0: pop is blocked, so only the push occurs.
- All flags are registered and derived from the next count:
  - empty_n = (count_nxt != 0)
  - full_n = (count_nxt != DEPTH)
  - almost_full = (count_nxt >= AF_THRESH)
- Latency: push to if_empty_n high is 1 cycle. Pop at count==DEPTH drives if_full_n high 1 cycle later.
- Reset values: count=0, if_empty_n=0, if_full_n=1, if_almost_full=0 (AF_THRESH>=1), if_num_data_valid=0.
- if_dout is don't-care while empty.
- Reset asserted mid-operation: all contents are discarded logically within one cycle, and reset dominates push/pop in that cycle.
- No wrap-around pointers. Occupancy counter range is 0..DEPTH; saturation is guaranteed by the flag gating.

Optional Feature:
- Macro SRL_FIFO_ERR_CHECK_EN adds output err_flags (2 bits): bit0 = sticky write-while-full, bit1 = sticky read-while-empty.
  - Each bit is set when the request is present with its ce high while the FIFO cannot accept it.
  - Cleared only by reset.
- Without the macro, the port and logic are absent and rejected requests are silently ignored.

Decomposition:
- Package srl_fifo_pkg:
  - clog2 constant function.
  - AF default expression.
  - err_flags bit-index localparams (ERR_OVF=0, ERR_UDF=1).
- Sub-module srl_fifo_shiftreg holds the storage only:
  - Ports: clk, we, addr, din, dout.
  - Shift on we, combinational read at addr, no reset.
- srl_fifo_ctrl instantiates srl_fifo_shiftreg and owns count, flags and error logic.

Test Plan:
- Setup: DATA_WIDTH=8, DEPTH=4, AF_THRESH=3.
- Fill/drain: push 0x11,0x22,0x33,0x44 on consecutive cycles -> full_n=0 after 4th edge, count=4, almost_full high from 3rd; pop 4 -> dout 0x11,0x22,0x33,0x44 in order, empty_n=0 after last.
- Simultaneous push/pop at count=2 (0xA1,0xA2) pushing 0xA3 -> count stays 2, dout 0xA2 next cycle, then 0xA3.
- Push while full (count=4, push 0x55) -> ignored, count=4, subsequent drain never yields 0x55; with SRL_FIFO_ERR_CHECK_EN err_flags=2'b01.
- Pop while empty after reset -> count stays 0, empty_n=0; with macro err_flags=2'b10.
- CE gating: if_write=1, if_write_ce=0 for 3 cycles -> count 0; same for read side.
- Reset mid-operation at count=3 with push asserted -> next cycle count=0, empty_n=0, full_n=1, almost_full=0.
- DEPTH=5 (non-power-of-two): 5 pushes reach full, order preserved.
